// File: rtl/dac_channel_scheduler.sv
// Buffers per-channel DAC words written over the bus and hands them to a shared
// serializer one channel at a time, round-robin, with optional periodic refresh.
module dac_channel_scheduler #(
  parameter logic [23:0] REFRESH_PERIOD = 24'd2000000,
  parameter logic [7:0]  START_TIMEOUT  = 8'd64,
  parameter logic [7:0]  CTRL_ADDR      = 8'hE0,
  parameter logic [3:0]  DAC_ADDR_HI    = 4'h4
) (
  input  logic        xclk,
  input  logic        reset,
  input  logic        write_qualified,
  input  logic [7:0]  ab,
  input  logic [11:0] db_in,
  input  logic        ser_busy,
  output logic        ser_start,
  output logic [11:0] ser_data,
  output logic [1:0]  ser_format,
  output logic [15:0] sync_mask,
  output logic [15:0] pending,
  output logic        refresh_en,
  output logic        timeout_err
);

  typedef enum logic [2:0] {IDLE, GRANT, WAIT_BUSY, SENDING, DONE} state_t;

  localparam logic [23:0] RCNT_LAST = REFRESH_PERIOD - 24'd1;
  localparam logic [7:0]  TCNT_LAST = START_TIMEOUT - 8'd1;

  state_t      state_q, state_d;
  logic [11:0] value_q [16];
  logic [11:0] value_d [16];
  logic [15:0] pending_q, pending_d;
  logic [3:0]  last_grant_q, last_grant_d;
  logic [3:0]  rptr_q, rptr_d;
  logic [23:0] rcnt_q, rcnt_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic [3:0]  ch_q, ch_d;
  logic        rehit_q, rehit_d;
  logic [11:0] ser_data_q, ser_data_d;
  logic [1:0]  ser_format_q, ser_format_d;
  logic [15:0] sync_mask_q, sync_mask_d;
  logic        refresh_en_q, refresh_en_d;
  logic        timeout_err_q, timeout_err_d;

  logic        dac_wr, ctrl_wr, refresh_hit;
  logic [15:0] set_vec, clear_vec;
  logic [3:0]  pick, rr_idx;
  logic        found;

  function automatic logic [1:0] format_of(input logic [3:0] ch);
    case (ch)
      4'd14:   return 2'd2;
      4'd15:   return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  always_comb begin
    dac_wr      = write_qualified && (ab[7:4] == DAC_ADDR_HI);
    ctrl_wr     = write_qualified && (ab == CTRL_ADDR);
    refresh_hit = refresh_en_q && (rcnt_q == RCNT_LAST);
    set_vec     = '0;
    if (dac_wr)      set_vec[ab[3:0]] = 1'b1;
    if (refresh_hit) set_vec[rptr_q]  = 1'b1;
  end

  // Round-robin: first pending channel strictly after the last one granted.
  always_comb begin
    pick   = last_grant_q;
    found  = 1'b0;
    rr_idx = last_grant_q;
    for (int i = 1; i <= 16; i++) begin
      rr_idx = last_grant_q + 4'(i);
      if (!found && pending_q[rr_idx]) begin
        pick  = rr_idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    value_d       = value_q;
    last_grant_d  = last_grant_q;
    rptr_d        = rptr_q;
    rcnt_d        = rcnt_q;
    tcnt_d        = tcnt_q;
    ch_d          = ch_q;
    rehit_d       = rehit_q;
    ser_data_d    = ser_data_q;
    ser_format_d  = ser_format_q;
    sync_mask_d   = sync_mask_q;
    refresh_en_d  = refresh_en_q;
    timeout_err_d = timeout_err_q;
    clear_vec     = '0;

    if (dac_wr) value_d[ab[3:0]] = db_in;
    if (ctrl_wr) begin
      refresh_en_d = db_in[0];
      if (db_in[1]) timeout_err_d = 1'b0;
    end

    if (!refresh_en_q) begin
      rcnt_d = '0;
    end else if (refresh_hit) begin
      rcnt_d = '0;
      rptr_d = rptr_q + 4'd1;
    end else begin
      rcnt_d = rcnt_q + 24'd1;
    end

    // rehit remembers a new request for the granted channel, so DONE keeps it pending.
    case (state_q)
      IDLE: begin
        if ((pending_q != 16'd0) && !ser_busy) begin
          state_d      = GRANT;
          ch_d         = pick;
          last_grant_d = pick;
          ser_data_d   = value_q[pick];
          ser_format_d = format_of(pick);
          sync_mask_d  = 16'd1 << pick;
          rehit_d      = set_vec[pick];
        end
      end
      GRANT: begin
        state_d = WAIT_BUSY;
        tcnt_d  = '0;
        rehit_d = rehit_q | set_vec[ch_q];
      end
      WAIT_BUSY: begin
        rehit_d = rehit_q | set_vec[ch_q];
        if (ser_busy) begin
          state_d = SENDING;
        end else if (tcnt_q == TCNT_LAST) begin
          timeout_err_d = 1'b1;
          sync_mask_d   = '0;
          state_d       = IDLE;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      SENDING: begin
        rehit_d = rehit_q | set_vec[ch_q];
        if (!ser_busy) state_d = DONE;
      end
      DONE: begin
        if (!rehit_q) clear_vec[ch_q] = 1'b1;
        sync_mask_d = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    pending_d = (pending_q & ~clear_vec) | set_vec;
  end

  always_ff @(posedge xclk) begin
    if (!reset) begin
      state_q       <= IDLE;
      for (int i = 0; i < 16; i++) value_q[i] <= 12'h800;
      pending_q     <= 16'hFFFF;
      last_grant_q  <= 4'hF;
      rptr_q        <= 4'd0;
      rcnt_q        <= '0;
      tcnt_q        <= '0;
      ch_q          <= 4'd0;
      rehit_q       <= 1'b0;
      ser_data_q    <= '0;
      ser_format_q  <= '0;
      sync_mask_q   <= '0;
      refresh_en_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      value_q       <= value_d;
      pending_q     <= pending_d;
      last_grant_q  <= last_grant_d;
      rptr_q        <= rptr_d;
      rcnt_q        <= rcnt_d;
      tcnt_q        <= tcnt_d;
      ch_q          <= ch_d;
      rehit_q       <= rehit_d;
      ser_data_q    <= ser_data_d;
      ser_format_q  <= ser_format_d;
      sync_mask_q   <= sync_mask_d;
      refresh_en_q  <= refresh_en_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign ser_start   = (state_q == GRANT);
  assign ser_data    = ser_data_q;
  assign ser_format  = ser_format_q;
  assign sync_mask   = sync_mask_q;
  assign pending     = pending_q;
  assign refresh_en  = refresh_en_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_dac_channel_scheduler.sv
// Bench for dac_channel_scheduler: serializer model, transfer log and a per-channel
// value model checked scenario by scenario.
module tb_dac_channel_scheduler;
  localparam int RP = 16;

  logic        xclk = 1'b0;
  logic        reset = 1'b0;
  logic        write_qualified = 1'b0;
  logic [7:0]  ab = 8'h00;
  logic [11:0] db_in = 12'h000;
  logic        ser_busy;
  logic        ser_start;
  logic [11:0] ser_data;
  logic [1:0]  ser_format;
  logic [15:0] sync_mask;
  logic [15:0] pending;
  logic        refresh_en;
  logic        timeout_err;

  logic model_busy = 1'b0;
  logic force_busy = 1'b0;
  logic start_seen = 1'b0;
  bit   never_busy = 1'b0;
  int   busy_len = 34;
  int   busy_left = 0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [11:0] mval [16];
  int log_ch[$];
  int log_data[$];
  int log_fmt[$];
  int log_cyc[$];
  int log_mask[$];

  assign ser_busy = model_busy | force_busy;

  dac_channel_scheduler #(.REFRESH_PERIOD(24'd16)) dut (
    .xclk(xclk), .reset(reset), .write_qualified(write_qualified), .ab(ab),
    .db_in(db_in), .ser_busy(ser_busy), .ser_start(ser_start), .ser_data(ser_data),
    .ser_format(ser_format), .sync_mask(sync_mask), .pending(pending),
    .refresh_en(refresh_en), .timeout_err(timeout_err)
  );

  always #5 xclk = ~xclk;
  always @(posedge xclk) cyc <= cyc + 1;

  function automatic int onehot_idx(input logic [15:0] m);
    int r = -1;
    int n = 0;
    for (int i = 0; i < 16; i++) if (m[i]) begin r = i; n++; end
    return (n == 1) ? r : -1;
  endfunction

  function automatic int fmt_model(input int ch);
    return (ch == 14) ? 2 : (ch == 15) ? 1 : 0;
  endfunction

  function automatic int next_rr(input logic [15:0] mask, input int last);
    for (int k = 1; k <= 16; k++) if (mask[(last + k) % 16]) return (last + k) % 16;
    return -1;
  endfunction

  // Log every start strobe as one transfer.
  always @(negedge xclk) begin
    if (ser_start === 1'b1) begin
      log_ch.push_back(onehot_idx(sync_mask));
      log_data.push_back(int'(ser_data));
      log_fmt.push_back(int'(ser_format));
      log_cyc.push_back(cyc);
      log_mask.push_back(int'(sync_mask));
    end
  end

  // Serializer: busy rises just after the start strobe and lasts busy_len cycles.
  always begin
    @(negedge xclk);
    start_seen = ser_start;
    @(posedge xclk);
    #2;
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) model_busy = 1'b0;
    end else if (start_seen === 1'b1 && !never_busy) begin
      busy_left  = busy_len;
      model_busy = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge xclk);
    #1;
  endtask

  task automatic clear_log();
    log_ch.delete(); log_data.delete(); log_fmt.delete(); log_cyc.delete(); log_mask.delete();
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [11:0] d);
    write_qualified = 1'b1;
    ab = a;
    db_in = d;
    if (a[7:4] == 4'h4) mval[a[3:0]] = d;
    tick(1);
    write_qualified = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget, output bit ok);
    while (log_ch.size() < n && budget > 0) begin tick(1); budget--; end
    ok = (log_ch.size() >= n);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    while (!(pending == 16'd0 && sync_mask == 16'd0 && ser_busy == 1'b0) && budget > 0) begin
      tick(1);
      budget--;
    end
    ok = (pending == 16'd0 && sync_mask == 16'd0 && ser_busy == 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(2);
    for (int i = 0; i < 16; i++) mval[i] = 12'h800;
    checks++; if (pending !== 16'hFFFF) begin failures++; $display("[TB] FAIL reset_pending: got %h, expected ffff", pending); end
    checks++; if (sync_mask !== 16'h0) begin failures++; $display("[TB] FAIL reset_sync_mask: got %h, expected 0", sync_mask); end
    checks++; if (ser_start !== 1'b0) begin failures++; $display("[TB] FAIL reset_ser_start: got %b, expected 0", ser_start); end
    checks++; if (ser_data !== 12'h0) begin failures++; $display("[TB] FAIL reset_ser_data: got %h, expected 0", ser_data); end
    checks++; if (ser_format !== 2'd0) begin failures++; $display("[TB] FAIL reset_ser_format: got %0d, expected 0", ser_format); end
    checks++; if (refresh_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_refresh_en: got %b, expected 0", refresh_en); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_timeout_err: got %b, expected 0", timeout_err); end
  endtask

  task automatic test_power_on_sweep();
    bit ok;
    int got;
    clear_log();
    reset = 1'b1;
    wait_log(16, 1500, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL sweep_count: got %0d transfers, expected 16", log_ch.size()); end
    for (int i = 0; i < 16; i++) begin
      got = (i < log_ch.size()) ? log_ch[i] : -1;
      checks++; if (got != i) begin failures++; $display("[TB] FAIL sweep_order[%0d]: got ch %0d, expected ch %0d", i, got, i); end
      got = (i < log_data.size()) ? log_data[i] : -1;
      checks++; if (got != int'(mval[i])) begin failures++; $display("[TB] FAIL sweep_data[%0d]: got %0h, expected %0h", i, got, mval[i]); end
      got = (i < log_fmt.size()) ? log_fmt[i] : -1;
      checks++; if (got != fmt_model(i)) begin failures++; $display("[TB] FAIL sweep_format[%0d]: got %0d, expected %0d", i, got, fmt_model(i)); end
    end
    wait_idle(200, ok);
    checks++; if (pending !== 16'h0) begin failures++; $display("[TB] FAIL sweep_pending_clear: got %h, expected 0", pending); end
  endtask

  task automatic test_latency();
    bit ok;
    int k;
    clear_log();
    k = cyc;
    bus_write(8'h43, 12'h5A5);
    wait_log(1, 10, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL latency_start_seen: got 0 transfers, expected 1"); end
    if (ok) begin
      checks++; if (log_cyc[0] != k + 2) begin failures++; $display("[TB] FAIL latency_cycles: got %0d, expected %0d", log_cyc[0] - k, 2); end
      checks++; if (log_data[0] != int'(mval[3])) begin failures++; $display("[TB] FAIL latency_data: got %0h, expected %0h", log_data[0], mval[3]); end
      checks++; if (log_mask[0] != 32'h0008) begin failures++; $display("[TB] FAIL latency_mask: got %0h, expected 0008", log_mask[0]); end
    end
    wait_idle(200, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL latency_idle: got pending %h, expected 0", pending); end
  endtask

  task automatic test_coalesce();
    bit ok;
    int n3;
    int last3;
    clear_log();
    bus_write(8'h43, 12'h0C3);
    wait_log(1, 10, ok);
    tick(5);
    bus_write(8'h43, 12'h111);
    bus_write(8'h43, 12'h222);
    wait_idle(400, ok);
    n3 = 0;
    last3 = -1;
    foreach (log_ch[i]) if (log_ch[i] == 3) begin n3++; last3 = log_data[i]; end
    checks++; if (n3 != 2) begin failures++; $display("[TB] FAIL coalesce_count: got %0d ch3 transfers, expected 2", n3); end
    checks++; if (last3 != int'(mval[3])) begin failures++; $display("[TB] FAIL coalesce_data: got %0h, expected %0h", last3, mval[3]); end
  endtask

  task automatic test_done_collision();
    bit ok;
    int n6;
    int last6;
    int budget;
    clear_log();
    bus_write(8'h46, 12'hA06);
    wait_log(1, 10, ok);
    tick(3);
    budget = 100;
    while (ser_busy && budget > 0) begin tick(1); budget--; end
    bus_write(8'h46, 12'hB06);
    wait_idle(200, ok);
    n6 = 0;
    last6 = -1;
    foreach (log_ch[i]) if (log_ch[i] == 6) begin n6++; last6 = log_data[i]; end
    checks++; if (n6 != 2) begin failures++; $display("[TB] FAIL done_collision_count: got %0d ch6 transfers, expected 2", n6); end
    checks++; if (last6 != int'(mval[6])) begin failures++; $display("[TB] FAIL done_collision_data: got %0h, expected %0h", last6, mval[6]); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int last;
    int exp_ch;
    int got;
    logic [15:0] mask;
    bus_write(8'h45, 12'h555);
    wait_idle(200, ok);
    clear_log();
    force_busy = 1'b1;
    tick(1);
    bus_write(8'h42, 12'h222);
    bus_write(8'h45, 12'h5A5);
    bus_write(8'h49, 12'h999);
    force_busy = 1'b0;
    wait_log(3, 300, ok);
    mask = 16'h0224;
    last = 5;
    for (int i = 0; i < 3; i++) begin
      exp_ch = next_rr(mask, last);
      mask[exp_ch] = 1'b0;
      last = exp_ch;
      got = (i < log_ch.size()) ? log_ch[i] : -1;
      checks++; if (got != exp_ch) begin failures++; $display("[TB] FAIL rr_order[%0d]: got ch %0d, expected ch %0d", i, got, exp_ch); end
      got = (i < log_data.size()) ? log_data[i] : -1;
      checks++; if (got != int'(mval[exp_ch])) begin failures++; $display("[TB] FAIL rr_data[%0d]: got %0h, expected %0h", i, got, mval[exp_ch]); end
    end
    wait_idle(300, ok);
  endtask

  task automatic test_timeout();
    bit ok;
    int g;
    clear_log();
    never_busy = 1'b1;
    bus_write(8'h47, 12'h777);
    wait_log(1, 10, ok);
    g = ok ? log_cyc[0] : cyc;
    while (cyc < g + 64) tick(1);
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL timeout_early: got %b, expected 0", timeout_err); end
    tick(1);
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("[TB] FAIL timeout_flag: got %b, expected 1", timeout_err); end
    checks++; if (sync_mask !== 16'h0) begin failures++; $display("[TB] FAIL timeout_mask: got %h, expected 0", sync_mask); end
    checks++; if (pending[7] !== 1'b1) begin failures++; $display("[TB] FAIL timeout_pending_kept: got %b, expected 1", pending[7]); end
    bus_write(8'hE0, 12'h002);
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL timeout_clear: got %b, expected 0", timeout_err); end
    never_busy = 1'b0;
    wait_idle(300, ok);
    checks++; if (log_data[log_data.size() - 1] != int'(mval[7])) begin failures++; $display("[TB] FAIL timeout_retry_data: got %0h, expected %0h", log_data[log_data.size() - 1], mval[7]); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL timeout_after_retry: got %b, expected 0", timeout_err); end
  endtask

  task automatic test_refresh();
    bit ok;
    int k;
    int exp_ch;
    clear_log();
    busy_len = 4;
    k = cyc;
    bus_write(8'hE0, 12'h001);
    checks++; if (refresh_en !== 1'b1) begin failures++; $display("[TB] FAIL refresh_enable: got %b, expected 1", refresh_en); end
    wait_log(17, 17 * RP + 60, ok);
    for (int n = 0; n < 17; n++) begin
      exp_ch = n % 16;
      if (n < log_ch.size()) begin
        checks++; if (log_ch[n] != exp_ch) begin failures++; $display("[TB] FAIL refresh_ch[%0d]: got %0d, expected %0d", n, log_ch[n], exp_ch); end
        checks++; if (log_cyc[n] != k + 2 + (n + 1) * RP) begin failures++; $display("[TB] FAIL refresh_time[%0d]: got %0d, expected %0d", n, log_cyc[n] - k, 2 + (n + 1) * RP); end
        checks++; if (log_data[n] != int'(mval[exp_ch])) begin failures++; $display("[TB] FAIL refresh_data[%0d]: got %0h, expected %0h", n, log_data[n], mval[exp_ch]); end
      end else begin
        checks++; failures++; $display("[TB] FAIL refresh_missing[%0d]: got %0d transfers, expected 17", n, log_ch.size());
      end
    end
    bus_write(8'hE0, 12'h000);
    wait_idle(200, ok);
    busy_len = 34;
  endtask

  task automatic test_random();
    bit ok;
    bit written [16];
    int last;
    int ch;
    int gap;
    logic [7:0] a;
    clear_log();
    busy_len = 6;
    for (int i = 0; i < 16; i++) written[i] = 1'b0;
    for (int i = 0; i < 60; i++) begin
      ch = $urandom_range(0, 15);
      a = ($urandom_range(0, 7) == 0) ? {4'h5, 4'(ch)} : {4'h4, 4'(ch)};
      if (a[7:4] == 4'h4) written[ch] = 1'b1;
      bus_write(a, 12'($urandom_range(0, 4095)));
      gap = $urandom_range(0, 3);
      if (gap > 0) tick(gap);
    end
    wait_idle(3000, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL random_idle: got pending %h, expected 0", pending); end
    for (int c = 0; c < 16; c++) begin
      if (written[c]) begin
        last = -1;
        foreach (log_ch[i]) if (log_ch[i] == c) last = log_data[i];
        checks++; if (last != int'(mval[c])) begin failures++; $display("[TB] FAIL random_last_value[%0d]: got %0h, expected %0h", c, last, mval[c]); end
      end
    end
    busy_len = 34;
  endtask

  task automatic test_reset_midtransfer();
    bit ok;
    int n;
    clear_log();
    bus_write(8'h41, 12'h123);
    wait_log(1, 10, ok);
    tick(5);
    reset = 1'b0;
    tick(1);
    for (int i = 0; i < 16; i++) mval[i] = 12'h800;
    checks++; if (pending !== 16'hFFFF) begin failures++; $display("[TB] FAIL midreset_pending: got %h, expected ffff", pending); end
    checks++; if (sync_mask !== 16'h0) begin failures++; $display("[TB] FAIL midreset_mask: got %h, expected 0", sync_mask); end
    checks++; if (ser_data !== 12'h0) begin failures++; $display("[TB] FAIL midreset_data: got %h, expected 0", ser_data); end
    n = log_ch.size();
    tick(3);
    checks++; if (log_ch.size() != n) begin failures++; $display("[TB] FAIL midreset_no_start: got %0d starts, expected 0", log_ch.size() - n); end
    reset = 1'b1;
    wait_log(n + 1, 80, ok);
    checks++; if (!ok || log_ch[n] != 0) begin failures++; $display("[TB] FAIL midreset_first_ch: got %0d, expected 0", ok ? log_ch[n] : -1); end
    checks++; if (!ok || log_data[n] != int'(mval[0])) begin failures++; $display("[TB] FAIL midreset_first_data: got %0h, expected %0h", ok ? log_data[n] : -1, mval[0]); end
  endtask

  initial begin
    test_reset();
    test_power_on_sweep();
    test_latency();
    test_coalesce();
    test_done_collision();
    test_round_robin();
    test_timeout();
    test_refresh();
    test_random();
    test_reset_midtransfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
